// File: rtl/conveyor_piston_arbiter.sv
// Round-robin arbiter sharing one sorting piston between N_LANE lanes, with extend/retract sequencing.
// Optional macro ABORT_CNT_EN adds an 8-bit saturating count of strokes aborted by emg.
module conveyor_piston_arbiter #(
  parameter int unsigned N_LANE  = 4,
  parameter int unsigned EXT_CYC = 8,
  parameter int unsigned RET_CYC = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LANE-1:0] lane_req,
  input  logic              warn,
  input  logic              emg,
  output logic [N_LANE-1:0] grant,
  output logic              piston_ext,
  output logic [N_LANE-1:0] done,
  output logic              busy,
  output logic              emg_active
`ifdef ABORT_CNT_EN
  ,
  output logic [7:0]        abort_cnt
`endif
);

  localparam int unsigned IDX_W = (N_LANE > 1) ? $clog2(N_LANE) : 1;
  localparam logic [CNT_W-1:0] EXT_LAST = CNT_W'(EXT_CYC - 1);
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LANE - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXTEND  = 3'd1;
  localparam logic [2:0] S_RETRACT = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_LANE-1:0] grant_q, grant_d;
  logic [N_LANE-1:0] done_q, done_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              piston_ext_q, piston_ext_d;
  logic              busy_q, busy_d;
  logic              emg_active_q, emg_active_d;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  int unsigned       sel_pos;

  // First requesting lane at or after the pointer, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_pos   = 0;
    for (int unsigned i = 0; i < N_LANE; i++) begin
      sel_pos = 32'(ptr_q) + i;
      if (sel_pos >= N_LANE) begin
        sel_pos = sel_pos - N_LANE;
      end
      if (!sel_found && lane_req[IDX_W'(sel_pos)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(sel_pos);
      end
    end
  end

  // Next-state and registered-output logic; emg overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;

    case (state_q)
      S_IDLE: begin
        if (!warn && sel_found) begin
          state_d = S_EXTEND;
          cnt_d   = '0;
          grant_d = N_LANE'(1) << sel_idx;
          owner_d = sel_idx;
        end
      end
      S_EXTEND: begin
        if (cnt_q == EXT_LAST) begin
          state_d = S_RETRACT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RETRACT: begin
        if (cnt_q == RET_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = grant_q;
          grant_d = '0;
          ptr_d   = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        state_d = S_RECOVER;
        cnt_d   = '0;
      end
      S_RECOVER: begin
        if (cnt_q == RET_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase

    // Aborted strokes leave the pointer untouched and never pulse done.
    if (emg) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      grant_d = '0;
      done_d  = '0;
      ptr_d   = ptr_q;
      owner_d = owner_q;
    end

    piston_ext_d = (state_d == S_EXTEND);
    busy_d       = (state_d == S_EXTEND) || (state_d == S_RETRACT);
    emg_active_d = (state_d == S_HOLD) || (state_d == S_RECOVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      owner_q      <= '0;
      ptr_q        <= '0;
      piston_ext_q <= 1'b0;
      busy_q       <= 1'b0;
      emg_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      piston_ext_q <= piston_ext_d;
      busy_q       <= busy_d;
      emg_active_q <= emg_active_d;
    end
  end

  assign grant      = grant_q;
  assign piston_ext = piston_ext_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign emg_active = emg_active_q;

`ifdef ABORT_CNT_EN
  logic [7:0] abort_cnt_q, abort_cnt_d;

  // Only strokes in flight count; emergencies from IDLE/HOLD/RECOVER do not.
  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (emg && ((state_q == S_EXTEND) || (state_q == S_RETRACT)) && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abort_cnt_q <= '0;
    end else begin
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_conveyor_piston_arbiter.sv
// Self-checking bench for conveyor_piston_arbiter: directed vector table plus randomized run vs. a behavioural model.
module tb_conveyor_piston_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned EXT = 8;
  localparam int unsigned RET = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] lane_req;
  logic         warn;
  logic         emg;
  logic [N-1:0] grant;
  logic         piston_ext;
  logic [N-1:0] done;
  logic         busy;
  logic         emg_active;
`ifdef ABORT_CNT_EN
  logic [7:0]   abort_cnt;
`endif

  conveyor_piston_arbiter #(.N_LANE(N), .EXT_CYC(EXT), .RET_CYC(RET), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .lane_req   (lane_req),
    .warn       (warn),
    .emg        (emg),
    .grant      (grant),
    .piston_ext (piston_ext),
    .done       (done),
    .busy       (busy),
    .emg_active (emg_active)
`ifdef ABORT_CNT_EN
    ,
    .abort_cnt  (abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: who owns the piston and how many cycles of each phase remain.
  int m_owner    = -1;
  int m_ext_left = 0;
  int m_ret_left = 0;
  int m_rec_left = 0;
  bit m_hold     = 1'b0;
  int m_next     = 0;
  int m_done     = -1;
  int m_aborts   = 0;

  function automatic void model_step();
    m_done = -1;
    if (rst) begin
      m_owner = -1; m_ext_left = 0; m_ret_left = 0; m_rec_left = 0;
      m_hold = 1'b0; m_next = 0; m_aborts = 0;
    end else if (emg) begin
      if (m_owner >= 0 && m_aborts < 255) m_aborts++;
      m_owner = -1; m_ext_left = 0; m_ret_left = 0;
      m_hold = 1'b1; m_rec_left = 0;
    end else if (m_hold) begin
      m_hold = 1'b0;
      m_rec_left = RET;
    end else if (m_rec_left > 0) begin
      m_rec_left--;
    end else if (m_owner >= 0) begin
      if (m_ext_left > 0) begin
        m_ext_left--;
        if (m_ext_left == 0) m_ret_left = RET;
      end else begin
        m_ret_left--;
        if (m_ret_left == 0) begin
          m_done  = m_owner;
          m_next  = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else if (!warn) begin
      for (int k = 0; k < N; k++) begin
        int l;
        l = (m_next + k) % N;
        if (m_owner < 0 && lane_req[l]) begin
          m_owner    = l;
          m_ext_left = EXT;
        end
      end
    end
  endfunction

  task automatic check_model();
    int eg, ed;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    ed = (m_done >= 0) ? (1 << m_done) : 0;
    chk("model_grant", int'(grant), eg);
    chk("model_piston_ext", int'(piston_ext), int'(m_owner >= 0 && m_ext_left > 0));
    chk("model_done", int'(done), ed);
    chk("model_busy", int'(busy), int'(m_owner >= 0));
    chk("model_emg_active", int'(emg_active), int'(m_hold || m_rec_left > 0));
    chk("grant_onehot0", int'($onehot0(grant)), 1);
    chk("done_with_emg_active", int'((|done) && emg_active), 0);
`ifdef ABORT_CNT_EN
    chk("model_abort_cnt", int'(abort_cnt), m_aborts);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit         r;
    logic [3:0] req;
    bit         w;
    bit         e;
    int         n;
    logic [3:0] g;
    bit         x;
    logic [3:0] d;
    bit         b;
    bit         ea;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input logic [3:0] req, input bit w, input bit e, input int n,
                     input logic [3:0] g, input bit x, input logic [3:0] d, input bit b, input bit ea);
    vec_t v;
    v.r = r; v.req = req; v.w = w; v.e = e; v.n = n;
    v.g = g; v.x = x; v.d = d; v.b = b; v.ea = ea;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; lane_req = '0; warn = 1'b0; emg = 1'b0;

    //   rst req    w  e  n   grant  ext done   busy emg_act
    add(1, 4'h0, 0, 0, 1,  4'h0, 0, 4'h0, 0, 0);  // reset state
    add(0, 4'h1, 0, 0, 1,  4'h1, 1, 4'h0, 1, 0);  // lane 0 granted
    add(0, 4'h1, 0, 0, 7,  4'h1, 1, 4'h0, 1, 0);  // extend cycle 8
    add(0, 4'h1, 0, 0, 1,  4'h1, 0, 4'h0, 1, 0);  // retract cycle 1
    add(0, 4'h1, 0, 0, 7,  4'h1, 0, 4'h0, 1, 0);  // retract cycle 8
    add(0, 4'h0, 0, 0, 1,  4'h0, 0, 4'h1, 0, 0);  // done[0]
    add(0, 4'h0, 0, 0, 1,  4'h0, 0, 4'h0, 0, 0);
    add(0, 4'hF, 0, 0, 1,  4'h2, 1, 4'h0, 1, 0);  // round robin -> lane 1
    add(0, 4'hF, 0, 0, 16, 4'h0, 0, 4'h2, 0, 0);
    add(0, 4'hF, 0, 0, 1,  4'h4, 1, 4'h0, 1, 0);  // one idle cycle then lane 2
    add(0, 4'hF, 0, 0, 16, 4'h0, 0, 4'h4, 0, 0);
    add(0, 4'hF, 0, 0, 1,  4'h8, 1, 4'h0, 1, 0);
    add(0, 4'hF, 0, 0, 16, 4'h0, 0, 4'h8, 0, 0);
    add(0, 4'hF, 0, 0, 1,  4'h1, 1, 4'h0, 1, 0);  // wrap to lane 0
    add(0, 4'h0, 0, 0, 16, 4'h0, 0, 4'h1, 0, 0);
    add(0, 4'h2, 1, 0, 3,  4'h0, 0, 4'h0, 0, 0);  // warn blocks grant
    add(0, 4'h2, 0, 0, 1,  4'h2, 1, 4'h0, 1, 0);  // resumes one edge after warn drops
    add(0, 4'h2, 1, 0, 3,  4'h2, 1, 4'h0, 1, 0);  // warn mid-extend
    add(0, 4'h2, 1, 0, 13, 4'h0, 0, 4'h2, 0, 0);  // stroke still completes
    add(0, 4'h0, 1, 0, 2,  4'h0, 0, 4'h0, 0, 0);
    add(0, 4'h4, 0, 0, 1,  4'h4, 1, 4'h0, 1, 0);  // lane 2 extend cycle 1
    add(0, 4'h4, 0, 0, 2,  4'h4, 1, 4'h0, 1, 0);  // extend cycle 3
    add(0, 4'h4, 0, 1, 1,  4'h0, 0, 4'h0, 0, 1);  // emg abort
    add(0, 4'h4, 0, 1, 2,  4'h0, 0, 4'h0, 0, 1);  // hold
    add(0, 4'h4, 0, 0, 1,  4'h0, 0, 4'h0, 0, 1);  // recover cycle 1
    add(0, 4'h4, 0, 0, 7,  4'h0, 0, 4'h0, 0, 1);  // recover cycle 8
    add(0, 4'h4, 0, 0, 1,  4'h0, 0, 4'h0, 0, 0);  // idle
    add(0, 4'h4, 0, 0, 1,  4'h4, 1, 4'h0, 1, 0);  // lane 2 re-granted
    add(0, 4'h4, 0, 0, 15, 4'h4, 0, 4'h0, 1, 0);  // last retract cycle
    add(0, 4'h5, 0, 1, 1,  4'h0, 0, 4'h0, 0, 1);  // emg wins, no done
    add(0, 4'h5, 0, 0, 9,  4'h0, 0, 4'h0, 0, 0);  // recovered
    add(0, 4'h5, 0, 0, 1,  4'h4, 1, 4'h0, 1, 0);  // pointer unchanged: lane 2 before lane 0
    add(0, 4'h5, 0, 0, 3,  4'h4, 1, 4'h0, 1, 0);  // extend cycle 4
    add(1, 4'h5, 0, 0, 1,  4'h0, 0, 4'h0, 0, 0);  // reset mid-extend
    add(0, 4'hA, 0, 0, 1,  4'h2, 1, 4'h0, 1, 0);  // pointer back to lane 0 -> lane 1 wins
    add(1, 4'h0, 0, 0, 1,  4'h0, 0, 4'h0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].r; lane_req = tbl[i].req; warn = tbl[i].w; emg = tbl[i].e;
      repeat (tbl[i].n) step();
      chk($sformatf("vec%0d_grant", i), int'(grant), int'(tbl[i].g));
      chk($sformatf("vec%0d_piston_ext", i), int'(piston_ext), int'(tbl[i].x));
      chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].d));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].b));
      chk($sformatf("vec%0d_emg_active", i), int'(emg_active), int'(tbl[i].ea));
    end

    // Randomized run: lanes hold requests until their done, sticky emg/warn bursts.
    rst = 1'b0; lane_req = '0; warn = 1'b0; emg = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] r;
      r = lane_req & ~done;
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 63) == 0) r = '0;
      lane_req = r;
      if (emg) emg = ($urandom_range(0, 3) != 0);
      else     emg = ($urandom_range(0, 99) < 2);
      if (warn) warn = ($urandom_range(0, 7) != 0);
      else      warn = ($urandom_range(0, 99) < 4);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
